// File: rtl/fetch_unit.sv
// Instruction fetch / memory-request sequencer for the multicycle MIPS datapath.
// Captures fetched words, holds data requests until dhit, and pulses pc_en on retire.
module fetch_unit #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000,
    parameter int          CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      pc,
    input  logic             ihit,
    input  logic [31:0]      imemload,
    input  logic             dhit,
    input  logic             dREN_req,
    input  logic             dWEN_req,
    input  logic             halt_req,
    output logic             imemREN,
    output logic [31:0]      imemaddr,
    output logic [31:0]      instruction,
    output logic             instr_valid,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halt,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        MEM    = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state, next_state;
    logic   capture;
    logic   go_mem;
    logic   mem_done;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= FETCH;
        else     state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        go_mem     = 1'b0;
        mem_done   = 1'b0;
        pc_en      = 1'b0;
        case (state)
            FETCH: begin
                if (ihit) begin
                    capture    = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (halt_req) begin
                    next_state = HALTED;
                end else if (dWEN_req || dREN_req) begin
                    go_mem     = 1'b1;
                    next_state = MEM;
                end else begin
                    pc_en      = 1'b1;
                    next_state = FETCH;
                end
            end
            MEM: begin
                if (dhit) begin
                    mem_done   = 1'b1;
                    pc_en      = 1'b1;
                    next_state = FETCH;
                end
            end
            HALTED:  next_state = HALTED;
            default: next_state = FETCH;
        endcase
    end

    // Gated by RST so the fetch request is low for the whole reset interval.
    assign imemREN     = (state == FETCH) && !RST;
    assign imemaddr    = pc;
    assign instr_valid = (state == EXEC) || (state == MEM);
    assign halt        = (state == HALTED);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)          instruction <= RESET_INSTR;
        else if (capture) instruction <= imemload;
    end

    // Write takes precedence so a load and a store are never requested together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dmemREN <= 1'b0;
            dmemWEN <= 1'b0;
        end else if (go_mem) begin
            dmemWEN <= dWEN_req;
            dmemREN <= dREN_req & ~dWEN_req;
        end else if (mem_done) begin
            dmemREN <= 1'b0;
            dmemWEN <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)        retired <= '0;
        else if (pc_en) retired <= retired + CNT_W'(1);
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and memory-request sequencer between the program counter and the control unit in the multicycle MIPS datapath. It presents the current PC to instruction memory, captures the returned word into an instruction register on `ihit`, and holds it stable for decode. It holds data-memory read/write requests until `dhit`, and issues a single-cycle `pc_en` advance pulse to the program counter when an instruction retires. It also latches halt and counts retired instructions.

## Interface
- `RESET_INSTR`, 32'h0000_0000 (NOP): value of `instruction` after reset.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `CLK` in 1: system clock; all state updates on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `pc` in 32: current PC from the program counter.
- `ihit` in 1: instruction memory has returned `imemload` this cycle.
- `imemload` in 32: instruction word from memory.
- `dhit` in 1: data memory access completes this cycle.
- `dREN_req` in 1: decoded load (from the control unit; valid while `instr_valid`).
- `dWEN_req` in 1: decoded store.
- `halt_req` in 1: decoded HALT.
- `imemREN` out 1: instruction read request.
- `imemaddr` out 32: instruction address, equal to `pc`.
- `instruction` out 32: instruction register, to the control unit.
- `instr_valid` out 1: `instruction` holds a fetched word being executed.
- `dmemREN` out 1: data read request.
- `dmemWEN` out 1: data write request.
- `pc_en` out 1: one-cycle PC advance pulse.
- `halt` out 1: processor halted (sticky).
- `retired` out `CNT_W`: count of `pc_en` pulses; wraps modulo 2^CNT_W.

## Operation
- FSM states: FETCH, EXEC, MEM, HALTED. Reset state is FETCH.
- FETCH:
  - `imemREN`=1, `imemaddr`=`pc`.
  - On `ihit`: `instruction`<=`imemload`, `instr_valid`<=1, next state EXEC. Otherwise stay in FETCH and keep requesting.
- EXEC (exactly one cycle):
  - `halt_req`=1: go to HALTED (highest priority; no `pc_en`, no data request).
  - Otherwise, if `dWEN_req` or `dREN_req`: go to MEM with `dmemWEN`<=`dWEN_req` and `dmemREN`<=`dREN_req & ~dWEN_req`. Write wins if both are asserted; the two outputs are never high together.
  - Otherwise: `pc_en`=1 this cycle, next state FETCH.
- MEM:
  - Registered `dmemREN`/`dmemWEN` are held constant until `dhit`.
  - On `dhit`: both clear at the edge, `pc_en`=1 in the `dhit` cycle, next state FETCH.
- HALTED: absorbing until `RST`. `halt`=1, `imemREN`=`dmemREN`=`dmemWEN`=`pc_en`=0, `instruction` frozen.
- `ihit` outside FETCH and `dhit` outside MEM are ignored, including when both are high together.
- `instr_valid`=1 in EXEC and MEM, 0 in FETCH and HALTED. `instruction` changes only on an `ihit` capture.
- `retired` increments on every cycle with `pc_en`=1. It is not incremented by HALT.
- `pc_en` is combinational from state and `dhit`. It is never asserted in FETCH or HALTED.

## Timing
- Reset values while `RST`=1, asynchronous:
  - state=FETCH, `instruction`=`RESET_INSTR`, `retired`=0.
  - `instr_valid`=`dmemREN`=`dmemWEN`=`halt`=0, `pc_en`=0.
  - `imemREN`=1 as soon as reset deasserts (it is forced 0 while `RST`=1).
- Zero-wait memory:
  - ALU/branch instruction: 2 cycles (FETCH, EXEC), `pc_en` in cycle 2.
  - Load/store with `dhit` in the first MEM cycle: 3 cycles, `pc_en` in cycle 3.
- Each memory wait cycle adds one cycle in FETCH or MEM.
- The program counter updates on the edge that ends a `pc_en` cycle. The next FETCH uses the new `pc`.
- Reset asserted mid-MEM or mid-FETCH drops all requests immediately. Fetch restarts from the post-reset `pc`.

## Test plan
- Reset, then `ihit`=1 with `imemload`=32'h0022_5022 (SUB), no data requests -> `instruction` captured after 1 cycle; `pc_en` pulses exactly one cycle later; `retired`=1; `imemREN` high again.
- `ihit` delayed 3 cycles -> `imemREN` held with `imemaddr`=`pc` for 4 cycles; `instruction` stays `RESET_INSTR` until capture.
- Load, `dREN_req`=1, `dhit` after 2 wait cycles -> `dmemREN`=1 for 3 cycles, `pc_en` only in the `dhit` cycle, `retired`+1.
- `dREN_req`=`dWEN_req`=1 together -> only `dmemWEN`=1; also assert `ihit` during MEM -> ignored, `instruction` unchanged.
- `halt_req` in EXEC -> `halt`=1 on the next edge, and every request and `pc_en` stays 0 for 20 cycles. Asserting `RST` then clears `halt` and resumes FETCH.
- `RST` asserted mid-MEM -> `dmemREN`/`dmemWEN` drop immediately (asynchronous reset), `retired`=0.
